// File: rtl/audio_pkg.sv
// Shared constants and types for the audio interface blocks.
package audio_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    // Widest pair the codec path supports; blocks narrow it per instance.
    typedef struct packed {
        logic [31:0] left;
        logic [31:0] right;
    } audio_pair_t;

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous sample-pair FIFO with registered ready and level.
module audio_pair_fifo
    import audio_pkg::*;
#(
    parameter type T     = audio_pair_t,
    parameter int  DEPTH = 4,
    parameter int  LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              pop_data,
    output logic          empty,
    output logic          ready,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;

    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            ready <= (level_nxt != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S DAC transmit engine with sample-pair FIFO and sticky underrun.
// Define AUDIO_DAC_HOLD_EN to replay the last pair on underrun.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset,
    input  logic                            audio_interface_BCLK,
    input  logic                            audio_interface_DACLRCK,
    output logic                            audio_interface_DACDAT,
    input  logic [DATA_WIDTH-1:0]           sample_left,
    input  logic [DATA_WIDTH-1:0]           sample_right,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            underrun,
    input  logic                            underrun_clear
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_hist;
    logic                   lrck_hist;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;

    // Edge pulses are registered so DACDAT lands 4 clocks after the pin edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_hist <= 1'b0;
            lrck_hist <= 1'b0;
            bclk_fall <= 1'b0;
            lrck_fall <= 1'b0;
            lrck_rise <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_interface_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], audio_interface_DACLRCK};
            bclk_hist <= bclk_sync[SYNC_STAGES-1];
            lrck_hist <= lrck_sync[SYNC_STAGES-1];
            bclk_fall <= bclk_hist & ~bclk_sync[SYNC_STAGES-1];
            lrck_fall <= lrck_hist & ~lrck_sync[SYNC_STAGES-1];
            lrck_rise <= ~lrck_hist & lrck_sync[SYNC_STAGES-1];
        end
    end

    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  frame_start;
    pair_t                 fifo_in;
    pair_t                 fifo_out;
    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] next_l;
    logic [DATA_WIDTH-1:0] next_r;

    assign fifo_in     = '{left: sample_left, right: sample_right};
    assign fifo_push   = sample_valid && sample_ready;
    assign frame_start = lrck_fall && (state != ST_LEFT);
    assign fifo_pop    = frame_start && !fifo_empty;

    audio_pair_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .ready     (sample_ready),
        .level     (fifo_level)
    );

`ifdef AUDIO_DAC_HOLD_EN
    logic [DATA_WIDTH-1:0] l_shadow;

    assign next_l = fifo_empty ? l_shadow : fifo_out.left;
    assign next_r = fifo_empty ? r_hold : fifo_out.right;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            l_shadow <= '0;
        end else if (frame_start) begin
            l_shadow <= next_l;
        end
    end
`else
    assign next_l = fifo_empty ? '0 : fifo_out.left;
    assign next_r = fifo_empty ? '0 : fifo_out.right;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state                  <= ST_SYNC;
            bit_cnt                <= '0;
            shift                  <= '0;
            r_hold                 <= '0;
            audio_interface_DACDAT <= 1'b0;
            underrun               <= 1'b0;
        end else begin
            if (frame_start && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clear) begin
                underrun <= 1'b0;
            end
            // The BCLK fall that coincides with an LRCK edge is the I2S delay slot.
            if (frame_start) begin
                state   <= ST_LEFT;
                bit_cnt <= '0;
                shift   <= next_l;
                r_hold  <= next_r;
            end else if (lrck_rise && state == ST_LEFT) begin
                state   <= ST_RIGHT;
                bit_cnt <= '0;
                shift   <= r_hold;
            end else if (bclk_fall && state != ST_SYNC) begin
                if (bit_cnt != CW'(DATA_WIDTH)) begin
                    audio_interface_DACDAT <= shift[DATA_WIDTH-1];
                    shift                  <= {shift[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt                <= bit_cnt + 1'b1;
                end else begin
                    audio_interface_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed/random bench for audio_dac_tx against a slot-level I2S model.
module tb_audio_dac_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          bclk   = 1'b1;
    logic          lrck   = 1'b1;
    logic          dacdat;
    logic [DW-1:0] s_l    = '0;
    logic [DW-1:0] s_r    = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [2:0]    level;
    logic          ur;
    logic          ur_clr = 1'b0;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_m;

    pair_m q[$];
    pair_m cur;
    pair_m shadow;
    bit    synced;
    bit    ur_exp;
    logic  last_bit;

    always #5 clk = ~clk;

    audio_dac_tx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_clk                 (clk),
        .reset_reset             (rst),
        .audio_interface_BCLK    (bclk),
        .audio_interface_DACLRCK (lrck),
        .audio_interface_DACDAT  (dacdat),
        .sample_left             (s_l),
        .sample_right            (s_r),
        .sample_valid            (s_valid),
        .sample_ready            (s_ready),
        .fifo_level              (level),
        .underrun                (ur),
        .underrun_clear          (ur_clr)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        synced   = 1'b0;
        ur_exp   = 1'b0;
        last_bit = 1'b0;
        shadow   = '{l: '0, r: '0};
        cur      = '{l: '0, r: '0};
    endtask

    task automatic push(logic [DW-1:0] l, logic [DW-1:0] r);
        int budget = 50;
        bit rdy;
        s_l     = l;
        s_r     = r;
        s_valid = 1'b1;
        do begin
            rdy = s_ready;
            @(negedge clk);
            budget--;
        end while (!rdy && budget > 0);
        s_valid = 1'b0;
        check("push_accept", 32'(rdy), 32'd1);
        if (rdy) q.push_back('{l: l, r: r});
    endtask

    // One LRCK half-period of n BCLK cycles; BCLK period = 16 clk.
    task automatic run_slot(int n, bit right, int rst_at);
        logic [DW-1:0] word;
        logic          exp;
        if (!right) begin
            synced = 1'b1;
            if (q.size() > 0) begin
                cur    = q.pop_front();
                shadow = cur;
            end else begin
                ur_exp = 1'b1;
`ifdef AUDIO_DAC_HOLD_EN
                cur = shadow;
`else
                cur = '{l: '0, r: '0};
`endif
            end
        end
        word = right ? cur.r : cur.l;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) lrck = right;
            if (!synced)      exp = 1'b0;
            else if (k == 0)  exp = last_bit;
            else if (k <= DW) exp = word[DW-k];
            else              exp = 1'b0;
            repeat (3) @(negedge clk);
            check("dac_before_lat", 32'(dacdat), 32'(last_bit));
            @(negedge clk);
            check("dac_at_lat", 32'(dacdat), 32'(exp));
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            repeat (4) @(negedge clk);
            check(right ? "dac_right" : "dac_left", 32'(dacdat), 32'(exp));
            check("underrun", 32'(ur), 32'(ur_exp));
            last_bit = exp;
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_dacdat", 32'(dacdat), 32'd0);
                check("rst_level", 32'(level), 32'd0);
                check("rst_ready", 32'(s_ready), 32'd0);
                rst = 1'b0;
                model_reset();
                @(negedge clk);
                check("rst_ready_after", 32'(s_ready), 32'd1);
                @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(int n);
        run_slot(n, 1'b0, -1);
        run_slot(n, 1'b1, -1);
        check("frame_level", 32'(level), 32'(q.size()));
    endtask

    task automatic clear_underrun();
        @(negedge clk);
        ur_clr = 1'b1;
        @(negedge clk);
        ur_clr = 1'b0;
        ur_exp = 1'b0;
        check("underrun_clear", 32'(ur), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pair_m p5;
        model_reset();

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_dacdat", 32'(dacdat), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_ready", 32'(s_ready), 32'd0);
        check("reset_underrun", 32'(ur), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(s_ready), 32'd1);
        repeat (4) @(negedge clk);

        // Idle: zero frame and underrun
        run_frame(32);
        clear_underrun();

        // Known pattern
        push(16'hA5F0, 16'h0F5A);
        check("level_one", 32'(level), 32'd1);
        run_frame(32);

        // Fill and back-pressure
        for (int i = 0; i < DEPTH; i++) push(DW'($urandom), DW'($urandom));
        check("full_ready", 32'(s_ready), 32'd0);
        check("full_level", 32'(level), 32'(DEPTH));
        p5      = '{l: DW'($urandom), r: DW'($urandom)};
        s_l     = p5.l;
        s_r     = p5.r;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("held_level", 32'(level), 32'(DEPTH));
        check("held_ready", 32'(s_ready), 32'd0);
        run_slot(32, 1'b0, -1);
        s_valid = 1'b0;
        q.push_back(p5);
        check("fifth_level", 32'(level), 32'(DEPTH));
        run_slot(32, 1'b1, -1);
        for (int i = 0; i < DEPTH; i++) run_frame(32);
        run_frame(32);
        clear_underrun();

        // Stream three pairs then starve
        for (int i = 0; i < 3; i++) push(DW'($urandom), DW'($urandom));
        for (int i = 0; i < 4; i++) run_frame(32);
        clear_underrun();

        // Reset mid left channel, then clean restart
        push(DW'($urandom), DW'($urandom));
        push(DW'($urandom), DW'($urandom));
        run_slot(32, 1'b0, 5);
        run_slot(32, 1'b1, -1);
        push(DW'($urandom), DW'($urandom));
        run_frame(32);

        // Short LRCK half-periods truncate each channel
        for (int i = 0; i < 3; i++) push(DW'($urandom), DW'($urandom));
        for (int i = 0; i < 3; i++) run_frame(10);
        check("trunc_level", 32'(level), 32'd0);
        run_frame(10);
        clear_underrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
